ifu_pc_gen: RTL and testbench
=============================

IFU_PC_GEN -- requirements
Module: ifu_pc_gen

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter BTB_IDX_W, default 4, BTB index width; entries = 2^BTB_IDX_W (16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 hold_flag_i  input  3  pipeline hold code; PC stalls when value >= 3'd1.
REQ-006 jump_flag_i  input  1  redirect request from execute (mispredict/jump/interrupt).
REQ-007 jump_addr_i  input  32  redirect target.
REQ-008 update_valid_i  input  1  resolved-branch update strobe from execute.
REQ-009 update_pc_i  input  32  address of resolved branch.
REQ-010 update_taken_i  input  1  actual branch outcome.
REQ-011 update_target_i  input  32  actual branch target.
REQ-012 pc_o  output  32  current fetch address, registered; feeds fetch bus and inst_addr_i of the IF/ID register.
REQ-013 predict_taken_o  output  1  prediction for pc_o, combinational from pc_o and BTB.
REQ-014 predict_addr_o  output  32  predicted next address for pc_o, combinational.

Function
REQ-015 BTB entry SHALL hold valid (1b), tag = pc[31:BTB_IDX_W+2], target (32b), 2-bit saturating counter ctr.
REQ-016 Lookup index SHALL be pc_o[BTB_IDX_W+1:2]; hit = valid && tag == pc_o[31:BTB_IDX_W+2].
REQ-017 predict_taken_o SHALL be hit && ctr[1].
REQ-018 predict_addr_o SHALL be entry target when predict_taken_o=1, else pc_o+4.
REQ-019 pc_o+4 SHALL be modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-020 Next-PC priority per edge: jump_flag_i=1 -> jump_addr_i; else hold (hold_flag_i>=1) -> pc_o unchanged; else predict_addr_o.
REQ-021 jump_flag_i SHALL override an active hold in the same cycle.
REQ-022 Latency: redirect or prediction visible on pc_o exactly one cycle after the sampling edge.
REQ-023 BTB update on edge when update_valid_i=1, at index update_pc_i[BTB_IDX_W+1:2], independent of hold_flag_i and jump_flag_i.
REQ-024 Update, tag hit: taken -> ctr+1 saturating at 2'b11, target<=update_target_i; not taken -> ctr-1 saturating at 2'b00, target unchanged.
REQ-025 Update, tag miss or invalid: taken -> allocate valid=1, tag, target, ctr=2'b10 (replacing any prior entry); not taken -> no change.
REQ-026 Lookup and update of the same entry in one cycle: lookup uses pre-update contents; new contents visible next cycle.
REQ-027 pc_o SHALL be word-aligned; jump_addr_i/update_target_i bits [1:0] SHALL be forced to 2'b00 when stored.

Reset
REQ-028 On rst=0, asynchronously: pc_o=RESET_ADDR, all valid=0, all ctr=2'b00, targets/tags don't-care; predict_taken_o=0, predict_addr_o=RESET_ADDR+4.
REQ-029 Reset asserted mid-operation SHALL discard pending redirect/update; first post-reset edge with no hold/jump yields pc_o=RESET_ADDR+4.
REQ-030 No state SHALL change while rst=0 regardless of other inputs.

Verification
REQ-031 Release reset, hold=0, no jumps, 4 cycles -> pc_o 0x0,0x4,0x8,0xC,0x10; predict_taken_o=0 throughout.
REQ-032 hold_flag_i=3'd2 for 3 cycles at pc_o=0x8 with jump_flag_i=1/jump_addr_i=0x100 on 2nd cycle -> pc_o 0x8,0x8,0x100, then 0x104.
REQ-033 update 0x20 taken->0x80 once -> fetching 0x20 gives predict_taken_o=1, predict_addr_o=0x80, next pc_o=0x80; one not-taken update -> ctr=01, predict_taken_o=0, predict_addr_o=0x24.
REQ-034 Three taken updates of 0x20 then four not-taken -> ctr saturates 11 then 00; aliasing 0x60 (same index, other tag) taken update replaces entry, 0x20 then misses.
REQ-035 pc_o=0xFFFF_FFFC, no hold/jump -> next pc_o=0x0; update of current pc_o in same cycle -> prediction changes only next cycle.
REQ-036 Assert rst=0 mid-stream with update_valid_i=1 and jump_flag_i=1 -> pc_o=RESET_ADDR immediately, all BTB entries miss after release.

Source files
------------

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: fetch PC generator with a direct-mapped BTB holding 2-bit taken counters.
// Redirects beat holds; BTB updates from execute land regardless of pipeline state.
module ifu_pc_gen #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          BTB_IDX_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  output logic [31:0] pc_o,
  output logic        predict_taken_o,
  output logic [31:0] predict_addr_o
);
  localparam int N  = 1 << BTB_IDX_W;
  localparam int TW = 30 - BTB_IDX_W;
  localparam logic [31:0] RST_PC = {RESET_ADDR[31:2], 2'b00};

  logic [31:0]          pc_q, pc_d, pc_plus4;
  logic [N-1:0]         valid_q, valid_d;
  logic [TW-1:0]        tag_q [N];
  logic [TW-1:0]        tag_d [N];
  logic [31:0]          tgt_q [N];
  logic [31:0]          tgt_d [N];
  logic [1:0]           ctr_q [N];
  logic [1:0]           ctr_d [N];
  logic [BTB_IDX_W-1:0] idx, uidx;
  logic                 hit, uhit;
  logic [1:0]           uctr;

  assign idx             = pc_q[BTB_IDX_W+1:2];
  assign hit             = valid_q[idx] && tag_q[idx] == pc_q[31:BTB_IDX_W+2];
  assign pc_plus4        = pc_q + 32'd4;
  assign predict_taken_o = hit && ctr_q[idx][1];
  assign predict_addr_o  = predict_taken_o ? tgt_q[idx] : pc_plus4;
  assign pc_o            = pc_q;

  assign uidx = update_pc_i[BTB_IDX_W+1:2];
  assign uhit = valid_q[uidx] && tag_q[uidx] == update_pc_i[31:BTB_IDX_W+2];
  assign uctr = ctr_q[uidx];

  always_comb begin
    pc_d = jump_flag_i ? {jump_addr_i[31:2], 2'b00} : (hold_flag_i != 3'd0) ? pc_q : predict_addr_o;
  end

  // Lookup above reads the _q arrays, so same-cycle updates only show up next cycle.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (update_valid_i && uhit) begin
      ctr_d[uidx] = update_taken_i ? ((uctr == 2'b11) ? uctr : uctr + 2'd1)
                                   : ((uctr == 2'b00) ? uctr : uctr - 2'd1);
      if (update_taken_i) tgt_d[uidx] = {update_target_i[31:2], 2'b00};
    end else if (update_valid_i && update_taken_i) begin
      valid_d[uidx] = 1'b1;
      tag_d[uidx]   = update_pc_i[31:BTB_IDX_W+2];
      tgt_d[uidx]   = {update_target_i[31:2], 2'b00};
      ctr_d[uidx]   = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RST_PC;
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b00;
      end
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end
endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb_ifu_pc_gen: directed vector table plus hand-written reset sequences for ifu_pc_gen.
module tb_ifu_pc_gen;
  logic        clk, rst;
  logic [2:0]  hold_flag_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        update_valid_i;
  logic [31:0] update_pc_i;
  logic        update_taken_i;
  logic [31:0] update_target_i;
  logic [31:0] pc_o;
  logic        predict_taken_o;
  logic [31:0] predict_addr_o;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic        uv;
    logic [31:0] up;
    logic        ut;
    logic [31:0] utg;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] pa;
  } vec_t;
  vec_t v[$];

  ifu_pc_gen dut (
    .clk(clk), .rst(rst), .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i), .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .update_target_i(update_target_i), .pc_o(pc_o),
    .predict_taken_o(predict_taken_o), .predict_addr_o(predict_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [2:0] hold, logic jf, logic [31:0] ja, logic uv, logic [31:0] up,
                              logic ut, logic [31:0] utg, logic [31:0] pc, logic pt, logic [31:0] pa);
    vec_t r;
    r.hold = hold; r.jf = jf; r.ja = ja; r.uv = uv; r.up = up; r.ut = ut; r.utg = utg;
    r.pc = pc; r.pt = pt; r.pa = pa;
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    hold_flag_i = x.hold; jump_flag_i = x.jf; jump_addr_i = x.ja;
    update_valid_i = x.uv; update_pc_i = x.up; update_taken_i = x.ut; update_target_i = x.utg;
  endtask

  task automatic chk3(input string n, input logic [31:0] pc, input logic pt, input logic [31:0] pa);
    chk({n, "_pc"}, pc_o, pc);
    chk({n, "_pt"}, {31'd0, predict_taken_o}, {31'd0, pt});
    chk({n, "_pa"}, predict_addr_o, pa);
  endtask

  task automatic idle();
    drive(mk(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0));
  endtask

  task automatic step(input string n, input vec_t x);
    drive(x);
    @(posedge clk);
    #1;
    chk3(n, x.pc, x.pt, x.pa);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2 rst = 1'b0;
    #1 chk3("reset", 32'h0, 1'b0, 32'h4);
    drive(mk(3'd0, 1'b1, 32'h300, 1'b1, 32'h0, 1'b1, 32'h50, 32'h0, 1'b0, 32'h0));
    @(posedge clk); @(posedge clk); #1;
    chk3("in_reset", 32'h0, 1'b0, 32'h4);
    idle();
    rst = 1'b1;
    #1 chk3("released", 32'h0, 1'b0, 32'h4);

    //      hold  jf    ja            uv    up            ut    utg           pc            pt    pa
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b0, 32'h8));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b0, 32'hC));
    v.push_back(mk(3'd2, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b0, 32'hC));
    v.push_back(mk(3'd2, 1'b1, 32'h103,      1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b0, 32'h104));
    v.push_back(mk(3'd2, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b0, 32'h104));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b0, 32'h108));
    v.push_back(mk(3'd0, 1'b1, 32'h10,       1'b1, 32'h20,       1'b1, 32'h83,       32'h10,       1'b0, 32'h14));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h14,       1'b0, 32'h18));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h18,       1'b0, 32'h1C));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h1C,       1'b0, 32'h20));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h20,       1'b1, 32'h80));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        32'h80,       1'b0, 32'h84));
    v.push_back(mk(3'd0, 1'b1, 32'h20,       1'b0, 32'h0,        1'b0, 32'h0,        32'h20,       1'b0, 32'h24));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 32'h90,       32'h20,       1'b1, 32'h90));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 32'h90,       32'h20,       1'b1, 32'h90));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 32'h94,       32'h20,       1'b1, 32'h94));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        32'h20,       1'b1, 32'h94));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        32'h20,       1'b0, 32'h24));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        32'h20,       1'b0, 32'h24));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        32'h20,       1'b0, 32'h24));
    v.push_back(mk(3'd7, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 32'hA0,       32'h20,       1'b0, 32'h24));
    v.push_back(mk(3'd7, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 32'hA4,       32'h20,       1'b1, 32'hA4));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h60,       1'b1, 32'hC0,       32'h20,       1'b0, 32'h24));
    v.push_back(mk(3'd0, 1'b1, 32'h60,       1'b0, 32'h0,        1'b0, 32'h0,        32'h60,       1'b1, 32'hC0));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h60,       1'b0, 32'h0,        32'h60,       1'b0, 32'h64));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        32'h60,       1'b0, 32'h64));
    v.push_back(mk(3'd1, 1'b0, 32'h0,        1'b1, 32'h60,       1'b1, 32'hCB,       32'h60,       1'b1, 32'hC8));
    v.push_back(mk(3'd0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,       1'b0, 32'h0,        32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFFC));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFF_FFFC, 1'b0, 32'h0));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40,      32'h0,        1'b0, 32'h4));
    v.push_back(mk(3'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, 32'h0,        32'hFFFF_FFFC, 1'b1, 32'h40));
    v.push_back(mk(3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h40,       1'b0, 32'h44));
    for (int i = 0; i < v.size(); i++) step($sformatf("v%0d", i), v[i]);

    // Same-cycle lookup/update: before the edge the old (miss) prediction must still show.
    drive(mk(3'd1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h1F0, 32'h0, 1'b0, 32'h0));
    #1 chk3("pre_upd", 32'h40, 1'b0, 32'h44);
    @(posedge clk); #1;
    chk3("post_upd", 32'h40, 1'b1, 32'h1F0);

    // Asynchronous reset mid-cycle with a redirect and an update pending.
    drive(mk(3'd0, 1'b1, 32'h200, 1'b1, 32'h8, 1'b1, 32'h300, 32'h0, 1'b0, 32'h0));
    #2 rst = 1'b0;
    #1 chk3("async_rst", 32'h0, 1'b0, 32'h4);
    @(posedge clk); #1;
    chk3("rst_hold", 32'h0, 1'b0, 32'h4);
    idle();
    rst = 1'b1;
    step("post_rst", mk(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0, 32'h8));
    step("flush8", mk(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8, 1'b0, 32'hC));
    step("flush60", mk(3'd0, 1'b1, 32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 32'h60, 1'b0, 32'h64));
    step("flush40", mk(3'd0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h44));
    step("flushfc", mk(3'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
